instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port branch_jump_signal, input, 1: redirect request from execute; takes precedence over all stalls.
REQ-006 SHALL have port branch_target, input, 32: redirect PC; bits [1:0] are forced to 0 when captured.
REQ-007 SHALL have port busywait, input, 1: global pipeline stall from data memory.
REQ-008 SHALL have port hazard_stall, input, 1: load-use stall from hazard unit.
REQ-009 SHALL have port i_mem_read, output, 1: instruction memory read request.
REQ-010 SHALL have port i_mem_address, output, 32: instruction memory address.
REQ-011 SHALL have port i_mem_readdata, input, 32: instruction word, valid in any cycle where i_mem_read=1 and i_mem_busywait=0.
REQ-012 SHALL have port i_mem_busywait, input, 1: instruction memory busy.
REQ-013 SHALL have ports pc_out, pc_4_out and instruction_out, outputs, 32 each, plus valid_out, output, 1: the registered IF/ID fields that feed decode.

Function
REQ-014 SHALL hold the internal state pc (32), buf_instr (32), redirect_pc (32) and a 3-state FSM {FETCH, HOLD, DISCARD}.
REQ-015 In FETCH and DISCARD, the block SHALL drive i_mem_read=1. In HOLD, it SHALL drive i_mem_read=0. i_mem_address SHALL equal pc in every state.
REQ-016 Once raised, i_mem_read and i_mem_address SHALL remain stable until i_mem_busywait=0 at a rising edge.
REQ-017 Priority at each edge SHALL be: reset, then branch_jump_signal, then (busywait OR hazard_stall), then i_mem_busywait, then normal advance.
REQ-018 FETCH, normal case (no redirect, no stall, i_mem_busywait=0): pc_out<=pc, pc_4_out<=pc+4, instruction_out<=i_mem_readdata, valid_out<=1, pc<=pc+4; state stays FETCH.
REQ-019 FETCH with i_mem_busywait=1 and no stall: IF/ID SHALL load a bubble (instruction_out=NOP_INSTR, valid_out=0, pc_out=pc_4_out=0); pc held.
REQ-020 FETCH with a stall: IF/ID held. If i_mem_busywait=0, buf_instr<=i_mem_readdata and state->HOLD; otherwise stay in FETCH.
REQ-021 HOLD with no stall and no redirect: IF/ID<={pc, pc+4, buf_instr, 1}, pc<=pc+4, state->FETCH.
REQ-022 HOLD with a stall: the block SHALL stay in HOLD with IF/ID and pc unchanged.
REQ-023 Redirect in FETCH with i_mem_busywait=0, or redirect in HOLD: pc<=target, IF/ID bubble, state->FETCH.
REQ-024 Redirect in FETCH with i_mem_busywait=1: redirect_pc<=target, IF/ID bubble, state->DISCARD, and the in-flight access SHALL NOT be aborted.
REQ-025 DISCARD: IF/ID SHALL hold a bubble. A further redirect SHALL overwrite redirect_pc (latest wins). When i_mem_busywait=0, the returned word SHALL be dropped, pc<=redirect_pc (or the new target if a redirect arrives that same edge), and state->FETCH.
REQ-026 A redirect SHALL flush IF/ID even while busywait or hazard_stall is high.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC+4=0), with no carry out.
REQ-028 Fetch-to-IF/ID latency SHALL be one edge after i_mem_busywait=0 when unstalled. Steady-state throughput SHALL be one instruction per cycle with a zero-wait memory.

Reset
REQ-029 While reset=0, asynchronously: pc=RESET_PC, state=FETCH, buf_instr=redirect_pc=0, pc_out=pc_4_out=0, instruction_out=NOP_INSTR, valid_out=0, and i_mem_read=0.
REQ-030 Reset asserted mid-access or in HOLD/DISCARD SHALL abandon all pending work. The first request after deassertion SHALL be to RESET_PC on the next cycle.

Verification
REQ-031 Zero-wait memory, no stalls, 4 cycles -> IF/ID pc_out 0,4,8,12 with matching instructions and valid_out=1 each cycle.
REQ-032 i_mem_busywait high 3 cycles at pc=8 -> 3 bubbles (valid_out=0, NOP), address held at 8, then pc_out=8 and pc 8->12.
REQ-033 Word returns at pc=16 while busywait=1 for 2 cycles -> state HOLD, i_mem_read=0, IF/ID unchanged; on release pc_out=16 with the buffered word, pc=20.
REQ-034 Redirect to 32'h104 while i_mem_busywait=1 at pc=20 -> DISCARD, word for 20 never appears, next request and next valid pc_out = 32'h104.
REQ-035 Redirect (target 32'h40) and busywait high in the same cycle -> IF/ID bubble, pc=32'h40.
REQ-036 Reset pulse during DISCARD, plus wrap test starting at pc=32'hFFFFFFFC -> outputs return to the reset values in REQ-029, next fetch at RESET_PC; after the wrap test the following pc=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, imem handshake and IF/ID register.
// Holds an early-returned word under stall and drops words orphaned by redirects.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_jump_signal,
   input  logic [31:0] branch_target,
   input  logic        busywait,
   input  logic        hazard_stall,
   output logic        i_mem_read,
   output logic [31:0] i_mem_address,
   input  logic [31:0] i_mem_readdata,
   input  logic        i_mem_busywait,
   output logic [31:0] pc_out,
   output logic [31:0] pc_4_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_pc;
   logic [31:0] r_buf_instr;
   logic [31:0] r_redirect_pc;
   logic [31:0] r_pc_out;
   logic [31:0] r_pc_4_out;
   logic [31:0] r_instr_out;
   logic        r_valid_out;

   logic [31:0] w_pc_nxt;
   logic [31:0] w_buf_nxt;
   logic [31:0] w_redir_nxt;
   logic [31:0] w_pc_out_nxt;
   logic [31:0] w_pc_4_out_nxt;
   logic [31:0] w_instr_nxt;
   logic        w_valid_nxt;

   logic        w_stall;
   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_4;

   assign w_stall    = busywait | hazard_stall;
   assign w_redirect = branch_jump_signal;
   assign w_target   = branch_target & 32'hFFFF_FFFC;
   assign w_pc_4     = r_pc + 32'd4;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_FETCH: begin
            if (w_redirect) begin
               w_state_nxt = i_mem_busywait ? S_DISCARD : S_FETCH;
            end else if (w_stall) begin
               w_state_nxt = i_mem_busywait ? S_FETCH : S_HOLD;
            end else begin
               w_state_nxt = S_FETCH;
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               w_state_nxt = S_FETCH;
            end else if (w_stall) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_state_nxt = S_FETCH;
            end
         end
         S_DISCARD: begin
            w_state_nxt = i_mem_busywait ? S_DISCARD : S_FETCH;
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

   // Output / datapath next-value logic
   always_comb begin
      w_pc_nxt       = r_pc;
      w_buf_nxt      = r_buf_instr;
      w_redir_nxt    = r_redirect_pc;
      w_pc_out_nxt   = r_pc_out;
      w_pc_4_out_nxt = r_pc_4_out;
      w_instr_nxt    = r_instr_out;
      w_valid_nxt    = r_valid_out;
      unique case (r_state)
         S_FETCH: begin
            if (w_redirect) begin
               w_pc_out_nxt   = 32'd0;
               w_pc_4_out_nxt = 32'd0;
               w_instr_nxt    = NOP_INSTR;
               w_valid_nxt    = 1'b0;
               if (i_mem_busywait) begin
                  w_redir_nxt = w_target;
               end else begin
                  w_pc_nxt = w_target;
               end
            end else if (w_stall) begin
               if (!i_mem_busywait) begin
                  w_buf_nxt = i_mem_readdata;
               end
            end else if (i_mem_busywait) begin
               w_pc_out_nxt   = 32'd0;
               w_pc_4_out_nxt = 32'd0;
               w_instr_nxt    = NOP_INSTR;
               w_valid_nxt    = 1'b0;
            end else begin
               w_pc_out_nxt   = r_pc;
               w_pc_4_out_nxt = w_pc_4;
               w_instr_nxt    = i_mem_readdata;
               w_valid_nxt    = 1'b1;
               w_pc_nxt       = w_pc_4;
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               w_pc_out_nxt   = 32'd0;
               w_pc_4_out_nxt = 32'd0;
               w_instr_nxt    = NOP_INSTR;
               w_valid_nxt    = 1'b0;
               w_pc_nxt       = w_target;
            end else if (!w_stall) begin
               w_pc_out_nxt   = r_pc;
               w_pc_4_out_nxt = w_pc_4;
               w_instr_nxt    = r_buf_instr;
               w_valid_nxt    = 1'b1;
               w_pc_nxt       = w_pc_4;
            end
         end
         S_DISCARD: begin
            // The outstanding word belongs to the old path; it is never used.
            w_pc_out_nxt   = 32'd0;
            w_pc_4_out_nxt = 32'd0;
            w_instr_nxt    = NOP_INSTR;
            w_valid_nxt    = 1'b0;
            if (i_mem_busywait) begin
               if (w_redirect) begin
                  w_redir_nxt = w_target;
               end
            end else begin
               w_pc_nxt = w_redirect ? w_target : r_redirect_pc;
            end
         end
         default: begin
            w_pc_nxt = r_pc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc          <= RESET_PC;
         r_buf_instr   <= 32'd0;
         r_redirect_pc <= 32'd0;
         r_pc_out      <= 32'd0;
         r_pc_4_out    <= 32'd0;
         r_instr_out   <= NOP_INSTR;
         r_valid_out   <= 1'b0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_buf_instr   <= w_buf_nxt;
         r_redirect_pc <= w_redir_nxt;
         r_pc_out      <= w_pc_out_nxt;
         r_pc_4_out    <= w_pc_4_out_nxt;
         r_instr_out   <= w_instr_nxt;
         r_valid_out   <= w_valid_nxt;
      end
   end

   // The request is gated by reset so it drops asynchronously.
   assign i_mem_read      = reset & (r_state != S_HOLD);
   assign i_mem_address   = r_pc;
   assign pc_out          = r_pc_out;
   assign pc_4_out        = r_pc_4_out;
   assign instruction_out = r_instr_out;
   assign valid_out       = r_valid_out;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random traffic.
// Expected values come from a transaction-level model of the fetch rules.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        branch_jump_signal;
   logic [31:0] branch_target;
   logic        busywait;
   logic        hazard_stall;
   logic        i_mem_read;
   logic [31:0] i_mem_address;
   logic [31:0] i_mem_readdata;
   logic        i_mem_busywait;
   logic [31:0] pc_out;
   logic [31:0] pc_4_out;
   logic [31:0] instruction_out;
   logic        valid_out;

   int n_checks;
   int n_errors;

   // Model: current fetch pc, a captured-but-undelivered word,
   // and a pending redirect whose in-flight word must be dropped.
   logic [31:0] m_pc;
   logic [31:0] m_word;
   logic [31:0] m_redir;
   bit          m_held;
   bit          m_drop;
   logic [31:0] e_pc;
   logic [31:0] e_pc4;
   logic [31:0] e_ins;
   logic        e_vld;

   instr_fetch #(
      .RESET_PC (RST_PC),
      .NOP_INSTR(NOP)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .branch_jump_signal(branch_jump_signal),
      .branch_target     (branch_target),
      .busywait          (busywait),
      .hazard_stall      (hazard_stall),
      .i_mem_read        (i_mem_read),
      .i_mem_address     (i_mem_address),
      .i_mem_readdata    (i_mem_readdata),
      .i_mem_busywait    (i_mem_busywait),
      .pc_out            (pc_out),
      .pc_4_out          (pc_4_out),
      .instruction_out   (instruction_out),
      .valid_out         (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[7:0] ^ 8'h5A, a[31:8]} ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bubble();
      e_pc  = 32'd0;
      e_pc4 = 32'd0;
      e_ins = NOP;
      e_vld = 1'b0;
   endtask

   task automatic deliver(input logic [31:0] w);
      e_pc  = m_pc;
      e_pc4 = m_pc + 32'd4;
      e_ins = w;
      e_vld = 1'b1;
      m_pc  = m_pc + 32'd4;
   endtask

   task automatic model_reset();
      m_pc   = RST_PC;
      m_word = 32'd0;
      m_redir = 32'd0;
      m_held = 0;
      m_drop = 0;
      bubble();
   endtask

   task automatic model_step(input bit bj, input logic [31:0] t,
                             input bit stall, input bit imbw);
      if (bj) begin
         bubble();
         if (m_drop || (!m_held && imbw)) begin
            if (imbw) begin
               m_drop  = 1;
               m_redir = t;
            end else begin
               m_drop = 0;
               m_pc   = t;
            end
         end else begin
            m_held = 0;
            m_pc   = t;
         end
      end else if (m_drop) begin
         bubble();
         if (!imbw) begin
            m_drop = 0;
            m_pc   = m_redir;
         end
      end else if (stall) begin
         if (!m_held && !imbw) begin
            m_held = 1;
            m_word = memf(m_pc);
         end
      end else if (m_held) begin
         m_held = 0;
         deliver(m_word);
      end else if (imbw) begin
         bubble();
      end else begin
         deliver(memf(m_pc));
      end
   endtask

   task automatic chk_ifid(input string p);
      chk({p, "_pc_out"}, pc_out, e_pc);
      chk({p, "_pc_4_out"}, pc_4_out, e_pc4);
      chk({p, "_instr"}, instruction_out, e_ins);
      chk({p, "_valid"}, {31'd0, valid_out}, {31'd0, e_vld});
   endtask

   // One clock: drive at the falling edge, check after the next one.
   task automatic cycle(input bit bj, input logic [31:0] t, input bit bw,
                        input bit hz, input bit imbw);
      branch_jump_signal = bj;
      branch_target      = t;
      busywait           = bw;
      hazard_stall       = hz;
      i_mem_busywait     = imbw;
      #1;
      i_mem_readdata = imbw ? $urandom : memf(i_mem_address);
      chk("mem_read", {31'd0, i_mem_read}, {31'd0, !m_held});
      chk("mem_addr", i_mem_address, m_pc);
      model_step(bj, t & 32'hFFFF_FFFC, bw | hz, imbw);
      @(posedge clk);
      @(negedge clk);
      chk_ifid("cyc");
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("rst_read", {31'd0, i_mem_read}, 32'd0);
      chk("rst_addr", i_mem_address, RST_PC);
      chk_ifid("rst");
      @(posedge clk);
      @(negedge clk);
      chk("rst2_read", {31'd0, i_mem_read}, 32'd0);
      chk_ifid("rst2");
      reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      branch_jump_signal = 1'b0;
      branch_target = 32'd0;
      busywait = 1'b0;
      hazard_stall = 1'b0;
      i_mem_busywait = 1'b0;
      i_mem_readdata = 32'd0;
      model_reset();

      do_reset();

      // Zero-wait streaming
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
      chk("stream_pc12", pc_out, 32'd12);
      chk("stream_addr16", i_mem_address, 32'd16);

      // Word returns under stall at pc=16, released two cycles later
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      chk("hold_read", {31'd0, i_mem_read}, 32'd0);
      cycle(0, 0, 0, 0, 0);
      chk("hold_pc16", pc_out, 32'd16);
      chk("hold_ins", instruction_out, memf(32'd16));

      // Redirect during a wait at pc=20
      cycle(1, 32'h104, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      chk("disc_valid", {31'd0, valid_out}, 32'd0);
      chk("disc_addr", i_mem_address, 32'h104);
      cycle(0, 0, 0, 0, 0);
      chk("disc_pc104", pc_out, 32'h104);

      // Three memory waits at pc=8
      cycle(1, 32'h8, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
      chk("wait_addr8", i_mem_address, 32'h8);
      cycle(0, 0, 0, 0, 0);
      chk("wait_pc8", pc_out, 32'h8);
      chk("wait_addr12", i_mem_address, 32'hC);

      // Redirect together with busywait, target bits [1:0] ignored
      cycle(1, 32'h43, 1, 0, 0);
      chk("rbw_valid", {31'd0, valid_out}, 32'd0);
      chk("rbw_addr", i_mem_address, 32'h40);

      // Reset while discarding
      cycle(1, 32'h200, 0, 1, 1);
      do_reset();
      cycle(0, 0, 0, 0, 0);
      chk("post_rst_pc", pc_out, RST_PC);

      // Wrap-around
      cycle(1, 32'hFFFF_FFFF, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_4_out, 32'd0);
      chk("wrap_addr", i_mem_address, 32'd0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
